// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM states,
// requester limits, counter sizing and small arithmetic helpers.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      HOLD
   } state_e;

   localparam int NREQ_MAX         = 8;
   localparam int IDX_W            = $clog2(NREQ_MAX);
   localparam int DEF_ACK_TIMEOUT  = 25000;
   localparam int DEF_LOCK_TIMEOUT = 200000;
   localparam int CNT_W = $clog2(((DEF_ACK_TIMEOUT > DEF_LOCK_TIMEOUT) ?
                                  DEF_ACK_TIMEOUT : DEF_LOCK_TIMEOUT) + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic cnt_t sat_inc(input cnt_t c);
      if (&c) begin
         return c;
      end else begin
         return c + 1'b1;
      end
   endfunction

   // Round-robin successor of a requester index, wrapping at n.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end else begin
         return idx + 1'b1;
      end
   endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Per-requester byte handshake bundle between producers and the scheduler.
interface uart_tx_sched_if #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      output req_ready
   );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first active request searching upward
// from ptr with wrap, returned as one-hot and as an index.
module rr_pick
   import uart_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  win_oh_o,
   output logic [IDX_W-1:0] win_idx_o
);

   logic found;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[k] && (k == (int'(ptr_i) + i) % NREQ)) begin
               found       = 1'b1;
               win_oh_o[k] = 1'b1;
               win_idx_o   = IDX_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte
// producers, with per-owner locking for multi-byte messages.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int ACK_TIMEOUT  = 25000,
   parameter int LOCK_TIMEOUT = 200000
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_sched_if.slave    req,
   input  logic              tx_busy,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              err_timeout
);

   state_e            state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  win_q;
   logic              lock_q;
   cnt_t              ack_cnt_q;
   cnt_t              lock_cnt_q;
   logic              busy_meta_q;
   logic              busy_s_q;
   logic [7:0]        tx_data_q;
   logic              tx_start_q;
   logic [NREQ-1:0]   grant_q;
   logic [NREQ-1:0]   ready_q;
   logic              busy_q;
   logic              err_q;

   logic [NREQ-1:0]   pick_oh;
   logic [IDX_W-1:0]  pick_idx;
   logic [7:0]        pick_byte;
   logic [7:0]        own_byte;
   logic              pick_last;
   logic              own_valid;
   logic              own_last;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req_i     (req.req_valid),
      .ptr_i     (ptr_q),
      .win_oh_o  (pick_oh),
      .win_idx_o (pick_idx)
   );

   // One-hot muxes: the IDLE winner and the current owner share the bus.
   always_comb begin
      pick_byte = '0;
      own_byte  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_oh[k]) pick_byte = pick_byte | req.req_data[8*k +: 8];
         if (grant_q[k]) own_byte  = own_byte  | req.req_data[8*k +: 8];
      end
   end

   assign pick_last = |(req.req_last  & pick_oh);
   assign own_valid = |(req.req_valid & grant_q);
   assign own_last  = |(req.req_last  & grant_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         lock_q      <= 1'b0;
         ack_cnt_q   <= '0;
         lock_cnt_q  <= '0;
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         grant_q     <= '0;
         ready_q     <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // tx_busy comes from the transmitter's own clock domain.
         busy_meta_q <= tx_busy;
         busy_s_q    <= busy_meta_q;
         ready_q     <= '0;
         err_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req.req_valid) begin
                  tx_data_q <= pick_byte;
                  grant_q   <= pick_oh;
                  ready_q   <= pick_oh;
                  win_q     <= pick_idx;
                  lock_q    <= ~pick_last;
                  ack_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= START;
               end
            end
            START: begin
               if (busy_s_q) begin
                  tx_start_q <= 1'b0;
                  state_q    <= BUSY;
               end else if (ack_cnt_q == cnt_t'(ACK_TIMEOUT)) begin
                  // Transmitter never answered: drop the byte and move on.
                  err_q      <= 1'b1;
                  tx_start_q <= 1'b0;
                  lock_q     <= 1'b0;
                  ptr_q      <= next_idx(win_q, NREQ);
                  grant_q    <= '0;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  tx_start_q <= 1'b1;
                  ack_cnt_q  <= sat_inc(ack_cnt_q);
               end
            end
            BUSY: begin
               if (!busy_s_q) begin
                  if (lock_q) begin
                     lock_cnt_q <= '0;
                     state_q    <= HOLD;
                  end else begin
                     ptr_q   <= next_idx(win_q, NREQ);
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (own_valid) begin
                  tx_data_q <= own_byte;
                  ready_q   <= grant_q;
                  lock_q    <= ~own_last;
                  ack_cnt_q <= '0;
                  state_q   <= START;
               end else if (lock_cnt_q == cnt_t'(LOCK_TIMEOUT)) begin
                  lock_q  <= 1'b0;
                  ptr_q   <= next_idx(win_q, NREQ);
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  lock_cnt_q <= sat_inc(lock_cnt_q);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_start      = tx_start_q;
   assign grant         = grant_q;
   assign busy          = busy_q;
   assign err_timeout   = err_q;
   assign req.req_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small UART transmitter model,
// a serial-line receiver and a scoreboard of expected (byte, owner) frames.
module tb_uart_tx_sched;

   localparam int NREQ  = 4;
   localparam int ACK   = 40;
   localparam int LOCK  = 60;
   localparam int BITC  = 4;
   localparam int DLY   = 3;
   localparam int LIM   = 3000;

   typedef struct packed {
      logic [7:0]      data;
      logic [NREQ-1:0] grant;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tx_busy = 1'b0;
   logic            tx_line = 1'b1;
   logic            stall = 1'b0;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            busy;
   logic            err_timeout;
   logic [NREQ-1:0] grant;

   int checks = 0;
   int errors = 0;

   exp_t            exq[$];
   logic [7:0]      rxq[$];
   logic [NREQ-1:0] gq[$];
   logic [8:0]      fq[NREQ][$];

   uart_tx_sched_if #(.NREQ(NREQ)) bus ();

   uart_tx_sched #(
      .NREQ         (NREQ),
      .ACK_TIMEOUT  (ACK),
      .LOCK_TIMEOUT (LOCK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (bus),
      .tx_busy     (tx_busy),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .grant       (grant),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Requesters: present queued bytes, hold them until req_ready is seen.
   for (genvar g = 0; g < NREQ; g++) begin : feed
      logic       v;
      logic       l;
      logic [7:0] d;
      assign bus.req_valid[g]        = v;
      assign bus.req_last[g]         = l;
      assign bus.req_data[8*g +: 8]  = d;
      initial begin
         logic [8:0] e;
         v = 1'b0;
         l = 1'b0;
         d = 8'h00;
         forever begin
            @(negedge clk);
            if (v && bus.req_ready[g]) v = 1'b0;
            if (!v && fq[g].size() != 0) begin
               e = fq[g].pop_front();
               d = e[7:0];
               l = e[8];
               v = 1'b1;
            end
         end
      end
   end

   // Transmitter model: not reset by rst, finishes any frame it started.
   int         mstate = 0;
   int         mcnt   = 0;
   int         bitn   = 0;
   logic [8:0] sh     = '0;
   always @(posedge clk) begin
      case (mstate)
         0: if (tx_start && !stall) begin
            sh <= {1'b1, tx_data};
            gq.push_back(grant);
            mcnt   <= 0;
            mstate <= 1;
         end
         1: if (mcnt == DLY - 1) begin
            tx_busy <= 1'b1;
            tx_line <= 1'b0;
            mcnt    <= 0;
            bitn    <= 0;
            mstate  <= 2;
         end else mcnt <= mcnt + 1;
         default: if (mcnt == BITC - 1) begin
            mcnt <= 0;
            if (bitn == 9) begin
               tx_busy <= 1'b0;
               tx_line <= 1'b1;
               mstate  <= 0;
            end else begin
               tx_line <= sh[0];
               sh      <= sh >> 1;
               bitn    <= bitn + 1;
            end
         end else mcnt <= mcnt + 1;
      endcase
   end

   // Serial receiver decoding the line LSB-first at mid-bit.
   initial begin
      logic [7:0] b;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_line == 1'b0) begin
            repeat (BITC/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BITC) @(negedge clk);
               b[i] = tx_line;
            end
            rxq.push_back(b);
            repeat (BITC) @(negedge clk);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic [NREQ-1:0] g);
      exp_t e;
      e.data  = d;
      e.grant = g;
      exq.push_back(e);
   endtask

   task automatic check_frame(input string tag);
      int              n;
      exp_t            e;
      logic [7:0]      b;
      logic [NREQ-1:0] g;
      n = 0;
      while (rxq.size() == 0 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_wait"}, rxq.size(), 1);
      if (rxq.size() != 0) begin
         e = exq.pop_front();
         b = rxq.pop_front();
         g = (gq.size() != 0) ? gq.pop_front() : '0;
         chk({tag, "_byte"}, b, e.data);
         chk({tag, "_owner"}, g, e.grant);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((busy || tx_busy) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_ready", bus.req_ready, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte from req0.
      @(posedge clk);
      expect_frame(8'hA5, 4'b0001);
      fq[0].push_back({1'b1, 8'hA5});
      n = 0;
      while (!bus.req_ready[0] && n < LIM) begin @(negedge clk); n++; end
      chk("s_ready", bus.req_ready[0], 1);
      chk("s_tx_data", tx_data, 8'hA5);
      chk("s_grant", grant, 4'b0001);
      chk("s_start_early", tx_start, 0);
      @(negedge clk);
      chk("s_start_on", tx_start, 1);
      chk("s_busy", busy, 1);
      n = 0;
      while (!tx_busy && n < LIM) begin @(negedge clk); n++; end
      chk("s_txbusy_wait", tx_busy, 1);
      chk("s_start_held", tx_start, 1);
      n = 0;
      while (tx_start && n < 20) begin @(negedge clk); n++; end
      chk("s_start_drop", n, 3);
      check_frame("s");
      n = 0;
      while (tx_busy && n < LIM) begin @(negedge clk); n++; end
      chk("s_grant_at_fall", grant, 4'b0001);
      n = 0;
      while (grant != 0 && n < 20) begin @(negedge clk); n++; end
      chk("s_grant_clr", n, 3);
      chk("s_idle", busy, 0);

      // Round-robin: every requester continuously valid, pointer starts at 1.
      @(posedge clk);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NREQ; i++) fq[i].push_back({1'b1, 8'(32 + 16*r + i)});
         for (int j = 0; j < NREQ; j++) begin
            int i;
            i = (j + 1) % NREQ;
            expect_frame(8'(32 + 16*r + i), NREQ'(1) << i);
         end
      end
      for (int k = 0; k < 2*NREQ; k++) check_frame("rr");
      wait_idle("rr_idle");

      // Locked three-byte message from req2 while req0 waits.
      @(posedge clk);
      fq[2].push_back({1'b0, 8'h48});
      fq[2].push_back({1'b0, 8'h49});
      fq[2].push_back({1'b1, 8'h0A});
      fq[0].push_back({1'b1, 8'h30});
      expect_frame(8'h48, 4'b0100);
      expect_frame(8'h49, 4'b0100);
      expect_frame(8'h0A, 4'b0100);
      expect_frame(8'h30, 4'b0001);
      for (int k = 0; k < 4; k++) check_frame("lk");
      wait_idle("lk_idle");

      // Acknowledge timeout: transmitter ignores tx_start.
      stall = 1'b1;
      @(posedge clk);
      fq[3].push_back({1'b1, 8'h77});
      n = 0;
      while (!tx_start && n < LIM) begin @(negedge clk); n++; end
      chk("a_start_wait", tx_start, 1);
      n = 0;
      while (!err_timeout && n < ACK + 20) begin @(negedge clk); n++; end
      chk("a_err_cycle", n, ACK);
      chk("a_start_off", tx_start, 0);
      chk("a_idle", busy, 0);
      chk("a_grant", grant, 0);
      @(negedge clk);
      chk("a_err_pulse", err_timeout, 0);
      stall = 1'b0;
      @(posedge clk);
      fq[0].push_back({1'b1, 8'h80});
      fq[3].push_back({1'b1, 8'h83});
      expect_frame(8'h80, 4'b0001);
      expect_frame(8'h83, 4'b1000);
      check_frame("a_next0");
      check_frame("a_next1");
      wait_idle("a_idle_end");

      // Lock timeout: req1 opens a message and goes silent, req3 waits.
      @(posedge clk);
      fq[1].push_back({1'b0, 8'h11});
      expect_frame(8'h11, 4'b0010);
      check_frame("lt");
      @(posedge clk);
      fq[3].push_back({1'b1, 8'h33});
      expect_frame(8'h33, 4'b1000);
      n = 0;
      while (tx_busy && n < LIM) begin @(negedge clk); n++; end
      chk("lt_hold_grant", grant, 4'b0010);
      n = 0;
      while (grant == 4'b0010 && n < LOCK + 50) begin @(negedge clk); n++; end
      chk("lt_cycle", n, LOCK + 4);
      chk("lt_grant_clr", grant, 0);
      check_frame("lt_next");
      wait_idle("lt_idle");

      // Reset during BUSY, then pointer must restart at 0.
      @(posedge clk);
      fq[1].push_back({1'b1, 8'h5A});
      expect_frame(8'h5A, 4'b0010);
      check_frame("r_pre");
      wait_idle("r_pre_idle");
      @(posedge clk);
      fq[2].push_back({1'b1, 8'h5B});
      expect_frame(8'h5B, 4'b0100);
      n = 0;
      while (!tx_start && n < LIM) begin @(negedge clk); n++; end
      n = 0;
      while (tx_start && n < LIM) begin @(negedge clk); n++; end
      chk("r_in_busy", busy, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("r_tx_start", tx_start, 0);
      chk("r_grant", grant, 0);
      chk("r_busy", busy, 0);
      chk("r_err", err_timeout, 0);
      chk("r_tx_data", tx_data, 0);
      chk("r_ready", bus.req_ready, 0);
      check_frame("r_frame");
      n = 0;
      while (tx_busy && n < LIM) begin @(negedge clk); n++; end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      fq[1].push_back({1'b1, 8'h61});
      fq[3].push_back({1'b1, 8'h63});
      expect_frame(8'h61, 4'b0010);
      expect_frame(8'h63, 4'b1000);
      check_frame("r_post0");
      check_frame("r_post1");
      wait_idle("r_idle");

      chk("end_scoreboard", exq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
